pattern_scan_controller: RTL and testbench

Frame-based controller for the shared 7-bit shift-register sequence detector datapath. On a start handshake it clears the detector window, latches a programmable pattern and frame length, and clocks exactly that many serial bits through the window. It counts pattern matches with saturation and reports completion with a one-cycle done pulse. It sits between a bit-serial source and the host that schedules detection frames.

---
 rtl/pattern_scan_controller.sv | 164 ++++++++++++++++
 tb/tb_pattern_scan_controller.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : pattern_scan_controller
// Description : Frame-based controller for a PATTERN_LEN-bit shift-register
//               sequence detector. An accepted start clears the window,
//               latches pattern and frame length, then clocks exactly
//               frame_len serial bits through the window while counting
//               pattern matches (saturating). A one-cycle done pulse marks
//               the end of the frame.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               start_i, abort_i   - frame request / running-frame abort
//               frame_len_i        - bits per frame, sampled on accept
//               pattern_i          - target sequence (MSB = oldest bit)
//               data_in_i          - serial bit, consumed on each RUN edge
//               busy_o, done_o     - RUN indicator / end-of-frame pulse
//               hit_o              - pulse per counted match
//               match_count_o      - matches in current/last frame
//               shift_regs_o       - window, newest bit in bit 0
// Config      : OVERLAP_EN - when defined, matches may share bits; when
//               undefined, each counted match needs PATTERN_LEN fresh bits.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_scan_controller #(
  parameter int PATTERN_LEN = 7,
  parameter int LEN_W       = 8,
  parameter int MATCH_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [LEN_W-1:0]       frame_len_i,
  input  logic [PATTERN_LEN-1:0] pattern_i,
  input  logic                   data_in_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   hit_o,
  output logic [MATCH_W-1:0]     match_count_o,
  output logic [PATTERN_LEN-1:0] shift_regs_o
);

  localparam int FILL_W = $clog2(PATTERN_LEN + 1);
  localparam logic [FILL_W-1:0] c_FILL_MAX = FILL_W'(PATTERN_LEN);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [PATTERN_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [MATCH_W-1:0]     match_q, match_d;
  logic [PATTERN_LEN-1:0] shift_q, shift_d;
  logic                   hit_q, hit_d;

  logic                   w_accept;
  logic [LEN_W-1:0]       w_bit_cnt_inc;
  logic [FILL_W-1:0]      w_fill_inc;
  logic [PATTERN_LEN-1:0] w_window;

  // start is honoured only when no frame is running
  assign w_accept      = start_i && ((state_q == c_IDLE) || (state_q == c_DONE));
  assign w_bit_cnt_inc = bit_cnt_q + LEN_W'(1);
  assign w_fill_inc    = (fill_q == c_FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
  assign w_window      = {shift_q[PATTERN_LEN-2:0], data_in_i};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = c_IDLE;
    case (state_q)
      c_IDLE, c_DONE: begin
        if (w_accept) begin
          state_d = (frame_len_i == '0) ? c_DONE : c_RUN;
        end else begin
          state_d = c_IDLE;
        end
      end
      c_RUN: begin
        if (abort_i) begin
          state_d = c_IDLE;
        end else if (w_bit_cnt_inc == len_q) begin
          state_d = c_DONE;
        end else begin
          state_d = c_RUN;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  // Output and datapath next-value logic
  always_comb begin
    busy_o    = (state_q == c_RUN);
    done_o    = (state_q == c_DONE);
    pat_d     = pat_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    fill_d    = fill_q;
    match_d   = match_q;
    shift_d   = shift_q;
    hit_d     = 1'b0;
    if (w_accept) begin
      pat_d     = pattern_i;
      len_d     = frame_len_i;
      bit_cnt_d = '0;
      fill_d    = '0;
      match_d   = '0;
      shift_d   = '0;
    end else if ((state_q == c_RUN) && !abort_i) begin
      // abort wins: no bit is consumed on an aborting edge
      shift_d   = w_window;
      bit_cnt_d = w_bit_cnt_inc;
      fill_d    = w_fill_inc;
      if ((w_window == pat_q) && (w_fill_inc == c_FILL_MAX)) begin
        hit_d   = 1'b1;
        match_d = (&match_q) ? match_q : match_q + MATCH_W'(1);
`ifdef OVERLAP_EN
        fill_d  = w_fill_inc;
`else
        // next match must be built entirely from bits after this one
        fill_d  = '0;
`endif
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q     <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      shift_q   <= '0;
      hit_q     <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      shift_q   <= shift_d;
      hit_q     <= hit_d;
    end
  end

  assign hit_o         = hit_q;
  assign match_count_o = match_q;
  assign shift_regs_o  = shift_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_scan_controller
// Description : Self-checking bench for pattern_scan_controller. Two DUTs
//               (MATCH_W=8 and MATCH_W=4) share one stimulus stream and are
//               compared each cycle against a frame-level model, plus
//               hand-computed expectations for the directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_scan_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] frame_len = '0;
  logic [6:0] pattern = '0;
  logic       data_in = 1'b0;

  logic       busy8, done8, hit8, busy4, done4, hit4;
  logic [7:0] mc8;
  logic [3:0] mc4;
  logic [6:0] sr8, sr4;

  int n_chk = 0;
  int n_err = 0;
  int hits8 = 0;

  always #5 clk = ~clk;

  pattern_scan_controller #(.PATTERN_LEN(7), .LEN_W(8), .MATCH_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .start_i(start), .abort_i(abort),
    .frame_len_i(frame_len), .pattern_i(pattern), .data_in_i(data_in),
    .busy_o(busy8), .done_o(done8), .hit_o(hit8),
    .match_count_o(mc8), .shift_regs_o(sr8)
  );

  pattern_scan_controller #(.PATTERN_LEN(7), .LEN_W(8), .MATCH_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .start_i(start), .abort_i(abort),
    .frame_len_i(frame_len), .pattern_i(pattern), .data_in_i(data_in),
    .busy_o(busy4), .done_o(done4), .hit_o(hit4),
    .match_count_o(mc4), .shift_regs_o(sr4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // phase: 0 = idle, 1 = scanning, 2 = done pulse
  int         ph = 0;
  int         m_len = 0;
  logic [6:0] m_pat = '0;
  bit         frame_bits[$];
  int         fresh = 0;      // bits available for the next match
  int         m_mc8 = 0;
  int         m_mc4 = 0;
  bit         m_hit = 0;

  // Last seven bits of the frame, newest in bit 0, zero before frame start
  function automatic logic [6:0] m_window();
    logic [6:0] w;
    int         idx;
    w = '0;
    for (int i = 0; i < 7; i++) begin
      idx = frame_bits.size() - 1 - i;
      if (idx >= 0) w[i] = frame_bits[idx];
    end
    return w;
  endfunction

  always @(posedge clk) begin
    m_hit = 0;
    if (reset) begin
      ph = 0;
      frame_bits.delete();
      fresh = 0;
      m_mc8 = 0;
      m_mc4 = 0;
    end else if (ph != 1) begin
      if (start) begin
        m_pat = pattern;
        m_len = int'(frame_len);
        frame_bits.delete();
        fresh = 0;
        m_mc8 = 0;
        m_mc4 = 0;
        ph = (frame_len == 0) ? 2 : 1;
      end else begin
        ph = 0;
      end
    end else if (abort) begin
      ph = 0;
    end else begin
      frame_bits.push_back(data_in);
      fresh++;
      if (m_window() == m_pat && fresh >= 7) begin
        m_hit = 1;
        if (m_mc8 < 255) m_mc8++;
        if (m_mc4 < 15) m_mc4++;
`ifndef OVERLAP_EN
        fresh = 0;
`endif
      end
      if (frame_bits.size() == m_len) ph = 2;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (hit8) hits8++;
    chk("busy8", 32'(busy8), 32'(ph == 1));
    chk("done8", 32'(done8), 32'(ph == 2));
    chk("hit8",  32'(hit8),  32'(m_hit));
    chk("mc8",   32'(mc8),   32'(m_mc8));
    chk("sr8",   32'(sr8),   32'(m_window()));
    chk("busy4", 32'(busy4), 32'(ph == 1));
    chk("done4", 32'(done4), 32'(ph == 2));
    chk("hit4",  32'(hit4),  32'(m_hit));
    chk("mc4",   32'(mc4),   32'(m_mc4));
    chk("sr4",   32'(sr4),   32'(m_window()));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic b);
    data_in = b;
    tick();
  endtask

  // Accept a frame, then scramble pattern/frame_len to show they are latched
  task automatic begin_frame(input int len, input logic [6:0] p);
    start = 1'b1;
    frame_len = 8'(len);
    pattern = p;
    tick();
    start = 1'b0;
    pattern = ~p;
    frame_len = 8'(len + 5);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  v7;
    logic [11:0] v12;

    repeat (3) tick();
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_hit",  32'(hit8), 0);
    chk("rst_mc",   32'(mc8), 0);
    chk("rst_sr",   32'(sr8), 0);
    reset = 1'b0;
    tick();

    // Reset mid-frame
    begin_frame(20, 7'b1111111);
    for (int i = 0; i < 5; i++) send(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 32'(busy8), 0);
    chk("midrst_done", 32'(done8), 0);
    chk("midrst_mc",   32'(mc8), 0);
    chk("midrst_sr",   32'(sr8), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_nodone", 32'(done8), 0);
    end

    // Single exact match on the last bit
    v7 = 7'b1010110;
    begin_frame(7, v7);
    for (int i = 6; i >= 0; i--) send(v7[i]);
    chk("m1_hit",  32'(hit8), 1);
    chk("m1_done", 32'(done8), 1);
    chk("m1_mc",   32'(mc8), 1);
    chk("m1_sr",   32'(sr8), 32'h56);
    tick();

    // Overlapping pattern occurrence
    hits8 = 0;
    v12 = 12'b101011010110;
    begin_frame(12, 7'b1010110);
    for (int i = 11; i >= 0; i--) send(v12[i]);
    chk("ov_done", 32'(done8), 1);
`ifdef OVERLAP_EN
    chk("ov_mc",   32'(mc8), 2);
    chk("ov_hits", 32'(hits8), 2);
`else
    chk("ov_mc",   32'(mc8), 1);
    chk("ov_hits", 32'(hits8), 1);
`endif

    // Zero-length frame, then back-to-back start in DONE
    start = 1'b1;
    frame_len = 8'd0;
    pattern = 7'b0000111;
    tick();
    chk("z_done", 32'(done8), 1);
    chk("z_busy", 32'(busy8), 0);
    chk("z_mc",   32'(mc8), 0);
    frame_len = 8'd3;
    tick();
    start = 1'b0;
    chk("b2b_busy0", 32'(busy8), 1);
    send(1'b1);
    chk("b2b_busy1", 32'(busy8), 1);
    send(1'b1);
    chk("b2b_busy2", 32'(busy8), 1);
    send(1'b1);
    chk("b2b_done", 32'(done8), 1);
    chk("b2b_busy3", 32'(busy8), 0);
    tick();

    // All-zero frames for saturation
    hits8 = 0;
    begin_frame(30, 7'b0000000);
    for (int i = 0; i < 30; i++) send(1'b0);
    chk("z30_done", 32'(done8), 1);
`ifdef OVERLAP_EN
    chk("z30_hits", 32'(hits8), 24);
    chk("z30_mc4",  32'(mc4), 15);
`else
    chk("z30_hits", 32'(hits8), 4);
    chk("z30_mc4",  32'(mc4), 4);
`endif
    tick();
    begin_frame(120, 7'b0000000);
    for (int i = 0; i < 120; i++) send(1'b0);
`ifdef OVERLAP_EN
    chk("z120_mc8", 32'(mc8), 114);
`else
    chk("z120_mc8", 32'(mc8), 17);
`endif
    chk("z120_mc4", 32'(mc4), 15);
    tick();

    // Abort after 4 of 10 bits, with an ignored start during RUN
    begin_frame(10, 7'b1100101);
    send(1'b1);
    send(1'b0);
    start = 1'b1;
    frame_len = 8'd5;
    send(1'b1);
    send(1'b1);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", 32'(busy8), 0);
    chk("ab_done", 32'(done8), 0);
    chk("ab_sr",   32'(sr8), 32'h0b);
    for (int i = 0; i < 3; i++) tick();

    // Abort after matches: count retained, abort in IDLE ignored
    begin_frame(20, 7'b0000000);
    for (int i = 0; i < 9; i++) send(1'b0);
    abort = 1'b1;
    tick();
    chk("ab2_busy", 32'(busy8), 0);
`ifdef OVERLAP_EN
    chk("ab2_mc", 32'(mc8), 3);
`else
    chk("ab2_mc", 32'(mc8), 1);
`endif
    tick();
    abort = 1'b0;
    chk("ab2_idle_done", 32'(done8), 0);

    // Pseudo-random frames checked by the model only
    for (int f = 0; f < 3; f++) begin
      begin_frame(25 + f * 10, (f == 0) ? 7'b0101010 : 7'(f * 37));
      for (int i = 0; i < 25 + f * 10; i++) send(1'($urandom_range(0, 1)));
      tick();
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
